motor_ramp_scheduler: RTL

MOTOR_RAMP_SCHEDULER -- requirements
Module: motor_ramp_scheduler

---
 rtl/motor_pkg.sv | 36 +++
 rtl/motor_ramp_scheduler_if.sv | 23 ++
 rtl/motor_ramp_channel.sv | 95 +++++++++
 rtl/motor_ramp_scheduler.sv | 115 +++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared types and constants for the two-channel motor ramp scheduler.
// Holds the channel FSM states and the signed-to-magnitude helper.
package motor_pkg;

    localparam int PWM_MAX = 100;

    typedef enum logic [1:0] {
        HOLD,
        RAMP_UP,
        RAMP_DOWN,
        DEAD
    } chan_state_e;

    typedef struct packed {
        logic       sign;
        logic [6:0] mag;
        logic       clamped;
    } sm_t;

    // Two's complement to sign+magnitude; -128 yields 128 before the clamp.
    function automatic sm_t to_sm(input logic [7:0] v, input logic [7:0] lim);
        sm_t        r;
        logic [7:0] a;
        a = v[7] ? (~v + 8'd1) : v;
        r.sign = ~v[7];
        if (a > lim) begin
            r.mag     = lim[6:0];
            r.clamped = 1'b1;
        end else begin
            r.mag     = a[6:0];
            r.clamped = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/motor_ramp_scheduler_if.sv
// Speed command handshake: two signed targets under valid/ready.
interface motor_ramp_scheduler_if;

    logic              cmd_valid;
    logic              cmd_ready;
    logic signed [7:0] cmd_m1;
    logic signed [7:0] cmd_m2;

    modport master (
        output cmd_valid,
        output cmd_m1,
        output cmd_m2,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_m1,
        input  cmd_m2,
        output cmd_ready
    );

endinterface

// File: rtl/motor_ramp_channel.sv
// One motor channel: ramp FSM, duty magnitude, direction and dead-time counter.
module motor_ramp_channel
    import motor_pkg::*;
#(
    parameter int RAMP_STEP  = 1,
    parameter int DEAD_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_tick,
    input  logic       i_estop,
    input  logic       i_tgt_sign,
    input  logic [6:0] i_tgt_mag,
    output logic       o_sign,
    output logic [6:0] o_mag,
    output logic       o_busy
);

    localparam int DW = (DEAD_TICKS < 2) ? 1 : $clog2(DEAD_TICKS + 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TICKS);
    localparam logic [6:0]    STEP      = 7'(RAMP_STEP);

    chan_state_e   r_state, w_state_nxt;
    logic          r_sign,  w_sign_nxt;
    logic [6:0]    r_mag,   w_mag_nxt;
    logic [DW-1:0] r_cnt,   w_cnt_nxt;

    logic          w_same;
    logic [6:0]    w_goal;
    logic [6:0]    w_dup;
    logic [6:0]    w_ddn;
    logic [6:0]    w_up;
    logic [6:0]    w_dn;
    logic [DW-1:0] w_cnt_inc;

    // A zero target never forces a reversal, so it counts as "same sign".
    assign w_same    = (i_tgt_sign == r_sign) || (i_tgt_mag == 7'd0);
    assign w_goal    = w_same ? i_tgt_mag : 7'd0;
    assign w_dup     = w_goal - r_mag;
    assign w_ddn     = r_mag - w_goal;
    assign w_up      = (w_dup < STEP) ? w_dup : STEP;
    assign w_dn      = (w_ddn < STEP) ? w_ddn : STEP;
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_sign_nxt  = r_sign;
        w_mag_nxt   = r_mag;
        w_cnt_nxt   = r_cnt;
        if (i_tick) begin
            if (r_state == DEAD && !w_same) begin
                w_mag_nxt = 7'd0;
                w_cnt_nxt = w_cnt_inc;
                if (w_cnt_inc == DEAD_LAST) begin
                    w_sign_nxt  = i_tgt_sign;
                    w_state_nxt = RAMP_UP;
                end
            end else if (r_mag < w_goal) begin
                w_mag_nxt   = r_mag + w_up;
                w_state_nxt = RAMP_UP;
            end else if (r_mag > w_goal) begin
                w_mag_nxt   = r_mag - w_dn;
                w_state_nxt = RAMP_DOWN;
            end else if (!w_same) begin
                w_cnt_nxt   = '0;
                w_state_nxt = DEAD;
            end else begin
                w_state_nxt = HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= HOLD;
            r_sign  <= 1'b1;
            r_mag   <= 7'd0;
            r_cnt   <= '0;
        end else if (i_estop) begin
            r_state <= HOLD;
            r_mag   <= 7'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sign  <= w_sign_nxt;
            r_mag   <= w_mag_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_sign = r_sign;
    assign o_mag  = r_mag;
    assign o_busy = (r_state != HOLD);

endmodule

// File: rtl/motor_ramp_scheduler.sv
// Two-channel PWM ramp scheduler: prescaler, command handshake and clamp,
// feeding one ramp channel per motor.
module motor_ramp_scheduler
    import motor_pkg::*;
#(
    parameter int PWM_MAX    = motor_pkg::PWM_MAX,
    parameter int RAMP_DIV   = 1000,
    parameter int RAMP_STEP  = 1,
    parameter int DEAD_TICKS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    motor_ramp_scheduler_if.slave  cmd,
    input  logic                   estop,
    output logic                   motor1_sign,
    output logic                   motor2_sign,
    output logic [6:0]             motor1_upperlimit,
    output logic [6:0]             motor2_upperlimit,
    output logic                   busy,
    output logic                   sat
);

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(RAMP_DIV - 1);
    localparam logic [7:0]    LIM   = 8'(PWM_MAX);

    logic [PW-1:0] r_presc;
    logic          r_ready;
    logic          r_sat;
    logic          r_t1_sign;
    logic [6:0]    r_t1_mag;
    logic          r_t2_sign;
    logic [6:0]    r_t2_mag;

    logic w_tick;
    logic w_acc;
    sm_t  w_sm1;
    sm_t  w_sm2;
    logic w_busy1;
    logic w_busy2;

    assign w_tick = (r_presc == PLAST);
    assign w_acc  = cmd.cmd_valid & r_ready;
    assign w_sm1  = to_sm(cmd.cmd_m1, LIM);
    assign w_sm2  = to_sm(cmd.cmd_m2, LIM);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Estop wins over a command accepted in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ready   <= 1'b0;
            r_sat     <= 1'b0;
            r_t1_sign <= 1'b1;
            r_t1_mag  <= 7'd0;
            r_t2_sign <= 1'b1;
            r_t2_mag  <= 7'd0;
        end else begin
            r_ready <= ~estop;
            r_sat   <= w_acc & ~estop & (w_sm1.clamped | w_sm2.clamped);
            if (estop) begin
                r_t1_mag <= 7'd0;
                r_t2_mag <= 7'd0;
            end else if (w_acc) begin
                r_t1_sign <= w_sm1.sign;
                r_t1_mag  <= w_sm1.mag;
                r_t2_sign <= w_sm2.sign;
                r_t2_mag  <= w_sm2.mag;
            end
        end
    end

    motor_ramp_channel #(
        .RAMP_STEP  (RAMP_STEP),
        .DEAD_TICKS (DEAD_TICKS)
    ) u_ch1 (
        .clk        (clk),
        .reset      (reset),
        .i_tick     (w_tick),
        .i_estop    (estop),
        .i_tgt_sign (r_t1_sign),
        .i_tgt_mag  (r_t1_mag),
        .o_sign     (motor1_sign),
        .o_mag      (motor1_upperlimit),
        .o_busy     (w_busy1)
    );

    motor_ramp_channel #(
        .RAMP_STEP  (RAMP_STEP),
        .DEAD_TICKS (DEAD_TICKS)
    ) u_ch2 (
        .clk        (clk),
        .reset      (reset),
        .i_tick     (w_tick),
        .i_estop    (estop),
        .i_tgt_sign (r_t2_sign),
        .i_tgt_mag  (r_t2_mag),
        .o_sign     (motor2_sign),
        .o_mag      (motor2_upperlimit),
        .o_busy     (w_busy2)
    );

    assign cmd.cmd_ready = r_ready;
    assign busy          = w_busy1 | w_busy2;
    assign sat           = r_sat;

endmodule
